// File: rtl/pc_call_stack.sv
// Program counter with configurable step, PC-relative branch and a return-address stack.
// Optional sticky misuse flag (stk_err) is enabled by defining PC_STACK_ERR_EN.
module pc_call_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int STEP  = 1,
  parameter int OFS_W = 8,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             Enable,
  input  logic             wren,
  input  logic [WIDTH-1:0] valor,
  input  logic             branch,
  input  logic [OFS_W-1:0] offset,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] Q,
  output logic             stk_full,
  output logic             stk_empty,
  output logic             stk_err
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [SPW-1:0]   SP_FULL = SPW'(DEPTH);

  logic [WIDTH-1:0] pc_q, pc_nxt, pc_inc, ofs_ext, br_tgt;
  logic [SPW-1:0]   sp_q, sp_nxt, sp_dec;
  logic             push;
  logic [WIDTH-1:0] mem [DEPTH];

  assign pc_inc    = pc_q + STEP_W;
  assign ofs_ext   = {{(WIDTH - OFS_W){offset[OFS_W-1]}}, offset};
  assign br_tgt    = pc_inc + ofs_ext;
  assign sp_dec    = sp_q - SPW'(1);
  assign stk_full  = (sp_q == SP_FULL);
  assign stk_empty = (sp_q == '0);
  assign Q         = pc_q;

  // Priority: wren > ret > call > branch > Enable
  always_comb begin
    pc_nxt = pc_q;
    sp_nxt = sp_q;
    push   = 1'b0;
    if (wren) begin
      pc_nxt = valor;
    end else if (ret) begin
      if (!stk_empty) begin
        sp_nxt = sp_dec;
        pc_nxt = mem[sp_dec[AW-1:0]];
      end
    end else if (call) begin
      pc_nxt = valor;
      if (!stk_full) begin
        push   = 1'b1;
        sp_nxt = sp_q + SPW'(1);
      end
    end else if (branch) begin
      pc_nxt = br_tgt;
    end else if (Enable) begin
      pc_nxt = pc_inc;
    end
  end

  always_ff @(negedge Clock or posedge Clear) begin
    if (Clear) begin
      pc_q <= RESET_ADDR;
      sp_q <= '0;
    end else begin
      pc_q <= pc_nxt;
      sp_q <= sp_nxt;
    end
  end

  // Stack contents need no reset; sp alone defines what is valid
  always_ff @(negedge Clock) begin
    if (push) mem[sp_q[AW-1:0]] <= pc_inc;
  end

`ifdef PC_STACK_ERR_EN
  logic err_q, err_evt;

  assign err_evt = !wren && ((ret && stk_empty) || (!ret && call && stk_full));

  always_ff @(negedge Clock or posedge Clear) begin
    if (Clear) err_q <= 1'b0;
    else       err_q <= err_q | err_evt;
  end

  assign stk_err = err_q;
`else
  assign stk_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_call_stack.sv
// Scoreboard bench for pc_call_stack: directed vectors then random ops vs a queue-based model.
module tb_pc_call_stack;

  localparam int DEPTH = 4;
`ifdef PC_STACK_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic        Clock, Clear, Enable, wren, branch, call, ret;
  logic [15:0] valor;
  logic [7:0]  offset;
  logic [15:0] Q;
  logic        stk_full, stk_empty, stk_err;

  pc_call_stack #(.WIDTH(16), .DEPTH(DEPTH), .STEP(1), .OFS_W(8), .RESET_ADDR(16'h0000)) dut (
    .Clock(Clock), .Clear(Clear), .Enable(Enable), .wren(wren), .valor(valor),
    .branch(branch), .offset(offset), .call(call), .ret(ret), .Q(Q),
    .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  typedef struct {
    logic [15:0] q;
    logic        full;
    logic        empty;
    logic        err;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: plain queue as the stack
  logic [15:0] m_q;
  logic [15:0] m_stk[$];
  logic        m_err;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q = 16'h0000;
    m_stk.delete();
    m_err = 1'b0;
  endtask

  task automatic do_op(input logic en, input logic wr, input logic [15:0] val,
                       input logic br, input logic [7:0] ofs,
                       input logic cl, input logic rt, input string tag);
    exp_t e;
    @(posedge Clock);
    #1;
    Enable = en; wren = wr; valor = val; branch = br; offset = ofs; call = cl; ret = rt;
    if (wr) m_q = val;
    else if (rt) begin
      if (m_stk.size() > 0) m_q = m_stk.pop_back();
      else m_err = 1'b1;
    end else if (cl) begin
      if (m_stk.size() < DEPTH) m_stk.push_back(m_q + 16'd1);
      else m_err = 1'b1;
      m_q = val;
    end else if (br) m_q = m_q + 16'd1 + {{8{ofs[7]}}, ofs};
    else if (en) m_q = m_q + 16'd1;
    e.q = m_q;
    e.full = (m_stk.size() == DEPTH);
    e.empty = (m_stk.size() == 0);
    e.err = ERR_ON & m_err;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic idle_inputs();
    Enable = 0; wren = 0; branch = 0; call = 0; ret = 0; valor = '0; offset = '0;
  endtask

  // Clear asserted between edges; outputs must reset before any clock edge
  task automatic mid_clear(input string tag);
    @(negedge Clock);
    #2 idle_inputs();
    #1 Clear = 1'b1;
    #1;
    model_reset();
    check({tag, "_q"}, Q, 16'h0000);
    check({tag, "_empty"}, {15'd0, stk_empty}, 16'd1);
    check({tag, "_full"}, {15'd0, stk_full}, 16'd0);
    check({tag, "_err"}, {15'd0, stk_err}, 16'd0);
    @(posedge Clock);
    #2 Clear = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.tag, "_q"}, Q, e.q);
        check({e.tag, "_full"}, {15'd0, stk_full}, {15'd0, e.full});
        check({e.tag, "_empty"}, {15'd0, stk_empty}, {15'd0, e.empty});
        check({e.tag, "_err"}, {15'd0, stk_err}, {15'd0, e.err});
      end
    end
  end

  initial begin : stim
    idle_inputs();
    Clear = 1'b1;
    model_reset();
    #1;
    check("rst_q", Q, 16'h0000);
    check("rst_empty", {15'd0, stk_empty}, 16'd1);
    check("rst_full", {15'd0, stk_full}, 16'd0);
    check("rst_err", {15'd0, stk_err}, 16'd0);
    @(posedge Clock);
    #2 Clear = 1'b0;

    for (int i = 0; i < 5; i++) do_op(1, 0, 0, 0, 0, 0, 0, "inc");
    mid_clear("clr_mid");

    do_op(0, 1, 16'hFFFF, 0, 0, 0, 0, "load_ffff");
    do_op(1, 0, 0, 0, 0, 0, 0, "inc_wrap");
    do_op(0, 1, 16'h0010, 0, 0, 0, 0, "load_10");
    do_op(0, 0, 0, 1, 8'hFC, 0, 0, "br_neg");
    do_op(0, 0, 0, 1, 8'h05, 0, 0, "br_pos");
    do_op(1, 0, 0, 1, 8'h80, 0, 0, "br_over_en");

    do_op(0, 1, 16'h0020, 0, 0, 0, 0, "load_20");
    do_op(0, 0, 16'h0100, 0, 0, 1, 0, "call1");
    do_op(0, 0, 0, 0, 0, 0, 1, "ret1");

    for (int i = 0; i < 4; i++) do_op(0, 0, 16'h0100 + 16'(i * 16), 0, 0, 1, 0, "call_fill");
    do_op(0, 0, 16'h0300, 0, 0, 1, 0, "call_full");
    for (int i = 0; i < 4; i++) do_op(0, 0, 0, 0, 0, 0, 1, "ret_unwind");
    do_op(0, 0, 0, 0, 0, 0, 1, "ret_empty");
    do_op(1, 0, 0, 0, 0, 0, 0, "inc_after_err");
    do_op(0, 0, 16'h0050, 0, 0, 1, 0, "call_pre");
    do_op(0, 1, 16'h0042, 0, 0, 1, 0, "wren_call");
    do_op(0, 1, 16'h0077, 0, 0, 0, 1, "wren_ret");
    do_op(0, 0, 16'h0999, 1, 8'h10, 1, 1, "ret_over_call");
    mid_clear("clr_err");

    for (int i = 0; i < 400; i++) begin
      if (i == 200) mid_clear("clr_rand");
      do_op($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 8, 16'($urandom),
            $urandom_range(0, 99) < 20, 8'($urandom),
            $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 25, "rand");
    end

    @(posedge Clock);
    #1 idle_inputs();
    repeat (4) @(negedge Clock);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
